gyruss_shram_arb: RTL and testbench
===================================

# gyruss_shram_arb

Arbiter and sequencer for the 2 KB work RAM shared between the Gyruss main CPU and the sub (sprite) CPU. Owns a single-port synchronous RAM and serializes byte accesses from two requesters with round-robin fairness and a fixed three-cycle access sequence. Sits between the main and sub CPU blocks in place of their direct shared-RAM connection. Optionally clears the RAM after reset.

## Interface
Parameters:
- AW, 11, RAM address width (2^AW bytes)
- DW, 8, data width
- CLR_VAL, 8'h00, fill value written by the clear sequence

Ports:
- MCLK  in  1  master clock; all logic on rising edge
- RESET_N  in  1  reset, synchronous, active-low
- A_REQ  in  1  main CPU request, level; hold with A_WE/A_ADDR/A_WDATA stable until A_ACK
- A_WE  in  1  main CPU: 1 = write, 0 = read
- A_ADDR  in  AW  main CPU byte address
- A_WDATA  in  DW  main CPU write data
- A_RDATA  out  DW  main CPU read data; valid from A_ACK and held until the next A access completes
- A_ACK  out  1  one-cycle completion pulse
- A_WAIT  out  1  A_REQ & ~A_ACK, combinational CPU stall
- B_REQ, B_WE, B_ADDR, B_WDATA, B_RDATA, B_ACK, B_WAIT: same as A, for the sub CPU
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: CLR (macro only), IDLE, ACC, RSP.
- IDLE: sample A_REQ/B_REQ. If none, stay. If one, grant it. If both, grant the port not in LAST. Latch grant, WE, ADDR, WDATA into internal registers, go to ACC.
- ACC: drive RAM address/WE/data from the latched registers for exactly one cycle; go to RSP.
- RSP: pulse ACK of the granted port. On reads, load that port's RDATA from RAM output. Set LAST = granted port. Go to IDLE.
- Writes update RAM at the end of ACC. The write is suppressed if RESET_N is low in that cycle.
- Round robin:
  - LAST resets to B, so A wins the first contention.
  - Continuous contention alternates A, B, A, B…
- Requester rule: REQ is sampled in IDLE only. A registered requester drops REQ the cycle after ACK, so it is not re-granted. REQ still high in IDLE after ACK counts as a new access.
- Other port's RDATA and ACK are untouched while one port is served.
- Read of an address written by the other port in the immediately preceding access returns the new data (strict serialization, no bypass needed).
- Address wrap: ADDR is used as-is; no out-of-range case exists.

## Timing
- Reset values:
  - A_ACK, B_ACK = 0; A_RDATA, B_RDATA = 0.
  - BUSY = 1 if clearing, else 0.
  - State = CLR (macro) or IDLE; LAST = B.
- Latency: REQ seen in IDLE at cycle n, ACC at n+1, ACK and RDATA at n+2, IDLE at n+3.
- Throughput: one access per 3 cycles. Two ports contending continuously each complete once per 6 cycles.
- Reset asserted mid-access: sequence aborted, no ACK issued, any pending write dropped. The requester keeps REQ and is re-served after reset.
- A_WAIT/B_WAIT are combinational from REQ and the registered ACK; no other combinational paths from inputs to outputs.

## Configuration
- SHRAM_CLEAR_EN defined:
  - After RESET_N deasserts, the CLR state writes CLR_VAL to addresses 0..2^AW-1, one per cycle (2048 cycles at AW=11), then enters IDLE.
  - REQs are ignored and BUSY=1 during CLR.
  - Reset during CLR restarts the clear at address 0.
- Undefined: no CLR state. Controller enters IDLE the first cycle after reset. RAM contents are not initialized and are retained across reset.

## Structure
- Shared package gyruss_pkg: state enum (CLR, IDLE, ACC, RSP), port-select constants PORT_A/PORT_B, default AW/DW.
- One sub-module, gyruss_shram_mem: inferred single-port synchronous RAM, 2^AW x DW, registered read output, write-first disabled (read-before-write irrelevant, single access per sequence).
- Arbiter FSM, latches and clear counter (AW+1 bits, terminal at 2^AW) live in gyruss_shram_arb.

## Test plan
- Single write/read: A writes 0x5A to 0x123, then reads 0x123. Each A_ACK comes 2 cycles after REQ is sampled, and the read returns A_RDATA=0x5A.
- Contention: A and B request in the same IDLE cycle after reset. A is served first (ACK at n+2), B second (ACK at n+5). On the next simultaneous request, B is served first.
- Cross-port visibility: B writes 0xC3 to 0x7FF and A then reads 0x7FF, getting 0xC3. B_RDATA is unchanged by A's access.
- Reset mid-write: A writes 0xFF to 0x010 with RESET_N low during ACC. No A_ACK, and a later read of 0x010 returns the prior value (CLR_VAL with macro).
- Clear sequence (SHRAM_CLEAR_EN): after reset, BUSY stays high for 2048 cycles and an early A_REQ is not acked until after the clear. Reads of 0x000, 0x400 and 0x7FF return 0x00.
- Back-to-back A with REQ held continuously: ACKs arrive every 3 cycles, and B_REQ raised meanwhile is served next (alternation).

Source files
------------

// File: rtl/gyruss_pkg.sv
// Shared types and defaults for the Gyruss shared work-RAM arbiter.
// Latency/backpressure: n/a (types, constants and the round-robin pick only).
package gyruss_pkg;

    localparam int DEF_AW = 11;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACC  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Single requester wins outright; on contention the port not served last wins.
    function automatic logic rr_pick(input logic a_req, input logic b_req, input logic last);
        if (a_req && b_req) begin
            return ~last;
        end
        return b_req ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/gyruss_shram_mem.sv
// Single-port synchronous RAM, 2^AW x DW, registered read that returns the pre-write contents.
// Latency: read data one cycle after an enabled access; no backpressure, accepts every enabled cycle.
module gyruss_shram_mem
    import gyruss_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gyruss_shram_arb.sv
// Main/sub CPU shared work-RAM arbiter: round-robin, IDLE->ACC->RSP, optional post-reset clear (SHRAM_CLEAR_EN).
// Latency: ACK two cycles after REQ is sampled in IDLE; backpressure: A_WAIT/B_WAIT stall each CPU until its ACK.
module gyruss_shram_arb
    import gyruss_pkg::*;
#(
    parameter int            AW      = DEF_AW,
    parameter int            DW      = DEF_DW,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_WDATA,
    output logic [DW-1:0] A_RDATA,
    output logic          A_ACK,
    output logic          A_WAIT,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_WDATA,
    output logic [DW-1:0] B_RDATA,
    output logic          B_ACK,
    output logic          B_WAIT,
    output logic          BUSY
);

`ifdef SHRAM_CLEAR_EN
    localparam state_t RST_STATE = ST_CLR;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_t        state_q;
    logic          last_q;
    logic          gnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic          busy_q;
    logic          gnt_d;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

`ifdef SHRAM_CLEAR_EN
    logic [AW:0]   clr_cnt_q;
    logic [AW:0]   clr_cnt_d;

    assign clr_cnt_d = clr_cnt_q + (AW+1)'(1);
`endif

    assign gnt_d = rr_pick(A_REQ, B_REQ, last_q);

    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_q   <= RST_STATE;
            last_q    <= PORT_B;
            gnt_q     <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= CLR_VAL;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            busy_q    <= RST_BUSY;
`ifdef SHRAM_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
`ifdef SHRAM_CLEAR_EN
                ST_CLR: begin
                    clr_cnt_q <= clr_cnt_d;
                    if (clr_cnt_d[AW]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                ST_IDLE: begin
                    if (A_REQ || B_REQ) begin
                        gnt_q   <= gnt_d;
                        we_q    <= (gnt_d == PORT_A) ? A_WE    : B_WE;
                        addr_q  <= (gnt_d == PORT_A) ? A_ADDR  : B_ADDR;
                        wdata_q <= (gnt_d == PORT_A) ? A_WDATA : B_WDATA;
                        state_q <= ST_ACC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACC: begin
                    a_ack_q <= (gnt_q == PORT_A);
                    b_ack_q <= (gnt_q == PORT_B);
                    state_q <= ST_RSP;
                end
                ST_RSP: begin
                    last_q <= gnt_q;
                    if (!we_q) begin
                        if (gnt_q == PORT_A) begin
                            a_rdata_q <= ram_rdata;
                        end else begin
                            b_rdata_q <= ram_rdata;
                        end
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write enable is gated by RESET_N so an access aborted by reset never lands in the RAM.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if (state_q == ST_ACC) begin
            ram_en = 1'b1;
            ram_we = we_q & RESET_N;
        end
`ifdef SHRAM_CLEAR_EN
        if (state_q == ST_CLR) begin
            ram_en    = 1'b1;
            ram_we    = RESET_N;
            ram_addr  = clr_cnt_q[AW-1:0];
            ram_wdata = CLR_VAL;
        end
`endif
    end

    gyruss_shram_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk_i   (MCLK),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // During RSP the read result is taken straight from the RAM register so it is valid alongside ACK.
    assign A_RDATA = (a_ack_q && !we_q) ? ram_rdata : a_rdata_q;
    assign B_RDATA = (b_ack_q && !we_q) ? ram_rdata : b_rdata_q;
    assign A_ACK   = a_ack_q;
    assign B_ACK   = b_ack_q;
    assign A_WAIT  = A_REQ & ~a_ack_q;
    assign B_WAIT  = B_REQ & ~b_ack_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_gyruss_shram_arb.sv
// Bench for gyruss_shram_arb: scoreboard of expected ACKs (port, cycle, read data) plus per-scenario checks.
module tb_gyruss_shram_arb;

    localparam int AW = 11;
    localparam int DW = 8;

`ifdef SHRAM_CLEAR_EN
    localparam logic          RST_BUSY_EXP = 1'b1;
    localparam logic [DW-1:0] PRIOR_EXP    = 8'h00;
`else
    localparam logic          RST_BUSY_EXP = 1'b0;
    localparam logic [DW-1:0] PRIOR_EXP    = 8'h33;
`endif

    typedef struct {
        bit            port;
        int            cyc;
        logic [DW-1:0] rdata;
        bit            chk;
    } exp_t;

    logic          MCLK;
    logic          RESET_N;
    logic          A_REQ, A_WE, B_REQ, B_WE;
    logic [AW-1:0] A_ADDR, B_ADDR;
    logic [DW-1:0] A_WDATA, B_WDATA, A_RDATA, B_RDATA;
    logic          A_ACK, A_WAIT, B_ACK, B_WAIT, BUSY;

    int            cyc   = 0;
    int            nchk  = 0;
    int            nfail = 0;
    exp_t          exp_q[$];
    exp_t          e_m;
    logic [1:0]    ack_v;
    logic [DW-1:0] rd_v [2];

    gyruss_shram_arb #(.AW(AW), .DW(DW), .CLR_VAL(8'h00)) dut (
        .MCLK(MCLK), .RESET_N(RESET_N),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_RDATA(A_RDATA), .A_ACK(A_ACK), .A_WAIT(A_WAIT),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_RDATA(B_RDATA), .B_ACK(B_ACK), .B_WAIT(B_WAIT),
        .BUSY(BUSY)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) cyc <= cyc + 1;

    // Every ACK pops the oldest expectation and must match its port, cycle and (for reads) data.
    always @(posedge MCLK) begin
        #2;
        ack_v    = {B_ACK, A_ACK};
        rd_v[0]  = A_RDATA;
        rd_v[1]  = B_RDATA;
        for (int p = 0; p < 2; p++) begin
            if (ack_v[p] === 1'b1) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL sb_unexpected_ack: port %0d ACK at cycle %0d, required no ACK", p, cyc);
                end else begin
                    e_m = exp_q.pop_front();
                    if (e_m.port !== p[0] || e_m.cyc != cyc || (e_m.chk && rd_v[p] !== e_m.rdata)) begin
                        nfail++;
                        $display("FAIL sb_ack: got port %0d cycle %0d rdata %02h, required port %0d cycle %0d rdata %02h (data checked %0d)",
                                 p, cyc, rd_v[p], e_m.port, e_m.cyc, e_m.rdata, e_m.chk);
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit p, input int c, input logic [DW-1:0] rd, input bit chk);
        exp_t e;
        e.port  = p;
        e.cyc   = c;
        e.rdata = rd;
        e.chk   = chk;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit p, input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (p == 1'b0) begin
            A_REQ = req; A_WE = we; A_ADDR = addr; A_WDATA = wd;
        end else begin
            B_REQ = req; B_WE = we; B_ADDR = addr; B_WDATA = wd;
        end
    endtask

    task automatic wait_ack(input bit p, input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge MCLK);
            if ((p == 1'b0 && A_ACK === 1'b1) || (p == 1'b1 && B_ACK === 1'b1)) break;
        end
        nchk++;
        if (i >= 20) begin
            nfail++;
            $display("FAIL %s_timeout: port %0d gave no ACK within 20 cycles, required an ACK", name, p);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && BUSY === 1'b1; i++) @(negedge MCLK);
        nchk++;
        if (BUSY !== 1'b0) begin
            nfail++;
            $display("FAIL idle_timeout: BUSY=%b after 3000 cycles, required 0", BUSY);
        end
    endtask

    task automatic do_acc(input bit p, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd_exp, input bit chk, input string name);
        @(negedge MCLK);
        drive(p, 1'b1, we, addr, wd);
        push_exp(p, cyc + 2, rd_exp, chk);
        wait_ack(p, name);
        drive(p, 1'b0, we, addr, wd);
    endtask

    task automatic apply_reset();
        @(negedge MCLK);
        RESET_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge MCLK);
        RESET_N = 1'b1;
        wait_idle();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge MCLK);
        nchk++; if (A_ACK !== 1'b0)          begin nfail++; $display("FAIL rst_a_ack: got %b, required 0", A_ACK); end
        nchk++; if (B_ACK !== 1'b0)          begin nfail++; $display("FAIL rst_b_ack: got %b, required 0", B_ACK); end
        nchk++; if (A_RDATA !== 8'h00)       begin nfail++; $display("FAIL rst_a_rdata: got %02h, required 00", A_RDATA); end
        nchk++; if (B_RDATA !== 8'h00)       begin nfail++; $display("FAIL rst_b_rdata: got %02h, required 00", B_RDATA); end
        nchk++; if (BUSY !== RST_BUSY_EXP)   begin nfail++; $display("FAIL rst_busy: got %b, required %b", BUSY, RST_BUSY_EXP); end
        drive(1'b0, 1'b1, 1'b0, 11'h000, 8'h00);
        #1;
        nchk++; if (A_WAIT !== 1'b1)         begin nfail++; $display("FAIL rst_a_wait: got %b, required 1", A_WAIT); end
        drive(1'b0, 1'b0, 1'b0, 11'h000, 8'h00);
        #1;
        nchk++; if (A_WAIT !== 1'b0)         begin nfail++; $display("FAIL rst_a_wait_low: got %b, required 0", A_WAIT); end
        @(negedge MCLK);
        RESET_N = 1'b1;
        wait_idle();
    endtask

`ifdef SHRAM_CLEAR_EN
    task automatic test_clear();
        int cnt;
        int r;
        @(negedge MCLK);
        RESET_N = 1'b0;
        repeat (2) @(negedge MCLK);
        RESET_N = 1'b1;
        r = cyc;
        cnt = 0;
        for (int i = 0; i < 3000 && BUSY === 1'b1; i++) begin
            cnt++;
            if (i == 10) begin
                drive(1'b0, 1'b1, 1'b0, 11'h400, 8'h00);
                push_exp(1'b0, r + 2050, 8'h00, 1'b1);
            end
            @(negedge MCLK);
        end
        nchk++; if (cnt != 2048) begin nfail++; $display("FAIL clr_busy_len: got %0d cycles, required 2048", cnt); end
        wait_ack(1'b0, "clr_early_req");
        drive(1'b0, 1'b0, 1'b0, 11'h400, 8'h00);
        do_acc(1'b0, 1'b0, 11'h000, 8'h00, 8'h00, 1'b1, "clr_rd_000");
        do_acc(1'b0, 1'b0, 11'h7FF, 8'h00, 8'h00, 1'b1, "clr_rd_7ff");
    endtask
`endif

    task automatic test_single();
        do_acc(1'b0, 1'b1, 11'h123, 8'h5A, 8'h00, 1'b0, "single_wr");
        do_acc(1'b0, 1'b0, 11'h123, 8'h00, 8'h5A, 1'b1, "single_rd");
        @(negedge MCLK);
        nchk++; if (A_RDATA !== 8'h5A) begin nfail++; $display("FAIL single_rdata_hold: got %02h, required 5A", A_RDATA); end
        nchk++; if (BUSY !== 1'b0)     begin nfail++; $display("FAIL single_busy_idle: got %b, required 0", BUSY); end
        drive(1'b0, 1'b1, 1'b1, 11'h124, 8'h77);
        push_exp(1'b0, cyc + 2, 8'h00, 1'b0);
        #1;
        nchk++; if (A_WAIT !== 1'b1)   begin nfail++; $display("FAIL single_wait: got %b, required 1", A_WAIT); end
        @(negedge MCLK);
        nchk++; if (BUSY !== 1'b1)     begin nfail++; $display("FAIL single_busy_acc: got %b, required 1", BUSY); end
        wait_ack(1'b0, "single_wr2");
        nchk++; if (A_WAIT !== 1'b0)   begin nfail++; $display("FAIL single_wait_ack: got %b, required 0", A_WAIT); end
        drive(1'b0, 1'b0, 1'b1, 11'h124, 8'h77);
    endtask

    task automatic test_contention();
        int n;
        apply_reset();
        @(negedge MCLK);
        n = cyc;
        drive(1'b0, 1'b1, 1'b1, 11'h200, 8'hA1);
        drive(1'b1, 1'b1, 1'b1, 11'h300, 8'hB1);
        push_exp(1'b0, n + 2, 8'h00, 1'b0);
        push_exp(1'b1, n + 5, 8'h00, 1'b0);
        push_exp(1'b0, n + 8, 8'h00, 1'b0);
        wait_ack(1'b1, "cont_b1");
        drive(1'b1, 1'b0, 1'b1, 11'h300, 8'hB1);
        wait_ack(1'b0, "cont_a2");
        drive(1'b0, 1'b0, 1'b1, 11'h200, 8'hA1);
        @(negedge MCLK);
        n = cyc;
        drive(1'b0, 1'b1, 1'b1, 11'h201, 8'hA2);
        drive(1'b1, 1'b1, 1'b1, 11'h301, 8'hB2);
        push_exp(1'b1, n + 2, 8'h00, 1'b0);
        push_exp(1'b0, n + 5, 8'h00, 1'b0);
        wait_ack(1'b1, "cont_b2");
        drive(1'b1, 1'b0, 1'b1, 11'h301, 8'hB2);
        wait_ack(1'b0, "cont_a3");
        drive(1'b0, 1'b0, 1'b1, 11'h201, 8'hA2);
    endtask

    task automatic test_cross();
        do_acc(1'b1, 1'b1, 11'h7FF, 8'hC3, 8'h00, 1'b0, "x_b_wr");
        do_acc(1'b0, 1'b0, 11'h7FF, 8'h00, 8'hC3, 1'b1, "x_a_rd");
        do_acc(1'b1, 1'b0, 11'h7FF, 8'h00, 8'hC3, 1'b1, "x_b_rd");
        do_acc(1'b0, 1'b1, 11'h7FE, 8'h96, 8'h00, 1'b0, "x_a_wr");
        do_acc(1'b0, 1'b0, 11'h7FE, 8'h00, 8'h96, 1'b1, "x_a_rd2");
        nchk++; if (B_RDATA !== 8'hC3) begin nfail++; $display("FAIL x_b_rdata_held: got %02h, required C3", B_RDATA); end
        nchk++; if (B_ACK !== 1'b0)    begin nfail++; $display("FAIL x_b_ack_quiet: got %b, required 0", B_ACK); end
    endtask

    task automatic test_reset_mid_write();
        do_acc(1'b0, 1'b1, 11'h010, 8'h33, 8'h00, 1'b0, "rmw_pre_wr");
        @(negedge MCLK);
        drive(1'b0, 1'b1, 1'b1, 11'h010, 8'hFF);
        @(negedge MCLK);
        RESET_N = 1'b0;
        @(negedge MCLK);
        nchk++; if (A_ACK !== 1'b0)        begin nfail++; $display("FAIL rmw_no_ack: got %b, required 0", A_ACK); end
        nchk++; if (BUSY !== RST_BUSY_EXP) begin nfail++; $display("FAIL rmw_busy: got %b, required %b", BUSY, RST_BUSY_EXP); end
        RESET_N = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 11'h010, 8'hFF);
        @(negedge MCLK);
        nchk++; if (A_ACK !== 1'b0)        begin nfail++; $display("FAIL rmw_no_ack_late: got %b, required 0", A_ACK); end
        wait_idle();
        do_acc(1'b0, 1'b0, 11'h010, 8'h00, PRIOR_EXP, 1'b1, "rmw_rd");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge MCLK);
        n = cyc;
        drive(1'b0, 1'b1, 1'b1, 11'h050, 8'h11);
        push_exp(1'b0, n + 2,  8'h00, 1'b0);
        push_exp(1'b0, n + 5,  8'h00, 1'b0);
        push_exp(1'b1, n + 8,  8'h00, 1'b0);
        push_exp(1'b0, n + 11, 8'h00, 1'b0);
        repeat (3) @(negedge MCLK);
        nchk++; if (A_WAIT !== 1'b1) begin nfail++; $display("FAIL b2b_wait_held: got %b, required 1", A_WAIT); end
        @(negedge MCLK);
        drive(1'b1, 1'b1, 1'b1, 11'h060, 8'h22);
        wait_ack(1'b1, "b2b_b");
        drive(1'b1, 1'b0, 1'b1, 11'h060, 8'h22);
        wait_ack(1'b0, "b2b_a3");
        drive(1'b0, 1'b0, 1'b1, 11'h050, 8'h11);
        do_acc(1'b0, 1'b0, 11'h050, 8'h00, 8'h11, 1'b1, "b2b_rd_a");
        do_acc(1'b1, 1'b0, 11'h060, 8'h00, 8'h22, 1'b1, "b2b_rd_b");
    endtask

    initial begin
        test_reset();
`ifdef SHRAM_CLEAR_EN
        test_clear();
`endif
        test_single();
        test_contention();
        test_cross();
        test_reset_mid_write();
        test_back_to_back();
        repeat (4) @(negedge MCLK);
        nchk++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL sb_leftover: %0d expected ACKs never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
